// File: rtl/sinalizador_jogadores_pkg.sv
// Shared definitions for the player signalling block.
// Holds the announcement type codes, the special player codes, the
// state encoding of the signalling FSM and a player one-hot decoder.
package polilobinho_pkg;

  localparam int N_LEDS = 5;

  // Announcement types carried on 'tipo'
  localparam logic [1:0] TIPO_CHAMAR      = 2'd0;
  localparam logic [1:0] TIPO_MORTE       = 2'd1;
  localparam logic [1:0] TIPO_VIT_LOBO    = 2'd2;
  localparam logic [1:0] TIPO_VIT_CIDADAO = 2'd3;

  // Player codes that do not address a LED
  localparam logic [2:0] JOGADOR_PULAR  = 3'd5;
  localparam logic [2:0] JOGADOR_NENHUM = 3'd7;

  // FSM state encoding
  localparam logic [2:0] EST_OCIOSO    = 3'd0;
  localparam logic [2:0] EST_CHAMA     = 3'd1;
  localparam logic [2:0] EST_PISCA_ON  = 3'd2;
  localparam logic [2:0] EST_PISCA_OFF = 3'd3;
  localparam logic [2:0] EST_VARRE     = 3'd4;
  localparam logic [2:0] EST_FIM       = 3'd5;

  // One-hot LED pattern for a player index; codes outside 0..N_LEDS-1
  // light nothing.
  function automatic logic [N_LEDS-1:0] decodifica_jogador(input logic [2:0] j);
    logic [N_LEDS-1:0] r;
    for (int i = 0; i < N_LEDS; i++) begin
      r[i] = (j == 3'(i));
    end
    return r;
  endfunction

endpackage

// File: rtl/sinalizador_jogadores_if.sv
// Bus between the game control unit (master) and the signalling block
// (slave).
// Handshake: the master raises 'iniciar' for one cycle together with
// 'tipo' and 'jogador'; the slave accepts it only while idle, holds
// 'ocupado' high while the pattern plays and answers with a one-cycle
// 'pronto'. Requests made while the slave is not idle are dropped.
// 'confirma' is a player pulse that only matters during a call.
// 'estado' exposes the FSM state for observation.
interface sinalizador_jogadores_if;
  import polilobinho_pkg::*;

  logic              iniciar;
  logic [1:0]        tipo;
  logic [2:0]        jogador;
  logic              confirma;
  logic [N_LEDS-1:0] leds_jogadores;
  logic              buzzer;
  logic              ocupado;
  logic              pronto;
  logic [2:0]        estado;

  modport master (
    output iniciar, tipo, jogador, confirma,
    input  leds_jogadores, buzzer, ocupado, pronto, estado
  );

  modport slave (
    input  iniciar, tipo, jogador, confirma,
    output leds_jogadores, buzzer, ocupado, pronto, estado
  );
endinterface

// File: rtl/sinalizador_jogadores_contador_ticks.sv
// Free-running tick counter for the signalling FSM.
// Ports: clock, reset (async, active-high), zera (synchronous clear),
// fim_tick (high while the count sits at TICKS-1).
module contador_ticks #(
  parameter int TICKS = 25000000
) (
  input  logic clock,
  input  logic reset,
  input  logic zera,
  output logic fim_tick
);
  import polilobinho_pkg::*;

  localparam int         W      = (TICKS > 1) ? $clog2(TICKS) : 1;
  localparam logic [W-1:0] ULTIMO = W'(TICKS - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (zera || (cnt_q == ULTIMO)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign fim_tick = (cnt_q == ULTIMO);
endmodule

// File: rtl/sinalizador_jogadores.sv
// Drives the five player LEDs and the buzzer with timed patterns:
// a steady call (until the player confirms), a blink for a death or a
// wolf victory, and a chase for a citizen victory.
// Ports: clock, reset (async, active-high), bus (slave side of
// sinalizador_jogadores_if: iniciar/tipo/jogador/confirma in,
// leds_jogadores/buzzer/ocupado/pronto/estado out).
module sinalizador_jogadores #(
  parameter int TICKS       = 25000000,
  parameter int N_PISCADAS  = 3,
  parameter int N_JOGADORES = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  sinalizador_jogadores_if.slave bus
);
  import polilobinho_pkg::*;

  localparam int WR = $clog2(N_PISCADAS + 1);
  localparam int WP = (N_JOGADORES > 1) ? $clog2(N_JOGADORES) : 1;

  logic [2:0]    estado_q, estado_d;
  logic [1:0]    tipo_q, tipo_d;
  logic [2:0]    jog_q, jog_d;
  logic [WR-1:0] rodadas_q, rodadas_d;
  logic [WP-1:0] pos_q, pos_d;
  logic          fim_tick;
  logic          zera;

  // The tick count restarts on every state change, so each state's
  // dwell is measured from its own first cycle.
  assign zera = (estado_d != estado_q);

  contador_ticks #(.TICKS(TICKS)) u_ticks (
    .clock    (clock),
    .reset    (reset),
    .zera     (zera),
    .fim_tick (fim_tick)
  );

  always_comb begin
    estado_d  = estado_q;
    tipo_d    = tipo_q;
    jog_d     = jog_q;
    rodadas_d = rodadas_q;
    pos_d     = pos_q;
    case (estado_q)
      EST_OCIOSO: begin
        if (bus.iniciar) begin
          tipo_d    = bus.tipo;
          jog_d     = bus.jogador;
          rodadas_d = '0;
          pos_d     = '0;
          case (bus.tipo)
            TIPO_CHAMAR:   estado_d = (bus.jogador < 3'(N_LEDS)) ? EST_CHAMA : EST_FIM;
            TIPO_MORTE:    estado_d = (bus.jogador < 3'(N_LEDS)) ? EST_PISCA_ON : EST_FIM;
            TIPO_VIT_LOBO: estado_d = EST_PISCA_ON;
            default:       estado_d = EST_VARRE;
          endcase
        end
      end
      EST_CHAMA: begin
        if (bus.confirma) estado_d = EST_FIM;
      end
      EST_PISCA_ON: begin
        if (fim_tick) estado_d = EST_PISCA_OFF;
      end
      EST_PISCA_OFF: begin
        if (fim_tick) begin
          rodadas_d = rodadas_q + 1'b1;
          estado_d  = (rodadas_d == WR'(N_PISCADAS)) ? EST_FIM : EST_PISCA_ON;
        end
      end
      EST_VARRE: begin
        if (fim_tick) begin
          if (pos_q == WP'(N_JOGADORES - 1)) begin
            // A full sweep across the players counts as one round.
            pos_d     = '0;
            rodadas_d = rodadas_q + 1'b1;
            if (rodadas_d == WR'(N_PISCADAS)) estado_d = EST_FIM;
          end else begin
            pos_d = pos_q + 1'b1;
          end
        end
      end
      EST_FIM:  estado_d = EST_OCIOSO;
      default:  estado_d = EST_OCIOSO;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q  <= EST_OCIOSO;
      tipo_q    <= '0;
      jog_q     <= '0;
      rodadas_q <= '0;
      pos_q     <= '0;
    end else begin
      estado_q  <= estado_d;
      tipo_q    <= tipo_d;
      jog_q     <= jog_d;
      rodadas_q <= rodadas_d;
      pos_q     <= pos_d;
    end
  end

  // Moore outputs decoded from the registered state.
  logic [N_LEDS-1:0] mascara;
  logic [N_LEDS-1:0] leds;
  logic              buzz, ocup, pront;

  assign mascara = (tipo_q == TIPO_VIT_LOBO) ? '1 : decodifica_jogador(jog_q);

  always_comb begin
    leds  = '0;
    buzz  = 1'b0;
    ocup  = 1'b0;
    pront = 1'b0;
    case (estado_q)
      EST_CHAMA: begin
        leds = decodifica_jogador(jog_q);
        ocup = 1'b1;
      end
      EST_PISCA_ON: begin
        leds = mascara;
        buzz = 1'b1;
        ocup = 1'b1;
      end
      EST_PISCA_OFF: ocup = 1'b1;
      EST_VARRE: begin
        leds = decodifica_jogador(3'(pos_q));
        ocup = 1'b1;
      end
      EST_FIM:  pront = 1'b1;
      default:  leds  = '0;
    endcase
  end

  assign bus.leds_jogadores = leds;
  assign bus.buzzer         = buzz;
  assign bus.ocupado        = ocup;
  assign bus.pronto         = pront;
  assign bus.estado         = estado_q;
endmodule

// File: tb/tb_sinalizador_jogadores.sv
// Bench for sinalizador_jogadores with TICKS=4, N_PISCADAS=3, N_JOGADORES=5.
module tb_sinalizador_jogadores;
  localparam int TK = 4;
  localparam int NP = 3;
  localparam int NJ = 5;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  sinalizador_jogadores_if bus();

  sinalizador_jogadores #(.TICKS(TK), .N_PISCADAS(NP), .N_JOGADORES(NJ)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // expected per-cycle observation: {leds[4:0], buzzer, ocupado, pronto}
  logic [7:0] exp_q[$];

  typedef struct {
    logic [1:0] tipo;
    logic [2:0] jogador;
    int         conf;  // CHAMA cycle in which confirma is pulsed
    int         ign;   // cycle of a stray iniciar (0 = none)
    int         lat;   // expected pronto cycle after the accept edge
  } vetor_t;

  vetor_t tabela[10];

  task automatic check8(input string nome, input int k, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s cycle %0d: got leds=%b bz/oc/pr=%b want leds=%b bz/oc/pr=%b",
               nome, k, act[7:3], act[2:0], exp_v[7:3], exp_v[2:0]);
    end
  endtask

  task automatic check_int(input string nome, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", nome, act, exp_v);
    end
  endtask

  function automatic logic [7:0] observa();
    return {bus.leds_jogadores, bus.buzzer, bus.ocupado, bus.pronto};
  endfunction

  // Reference model: lists what each cycle after the accept edge must show.
  task automatic build_expected(input logic [1:0] t, input logic [2:0] j, input int d);
    logic [4:0] um;
    logic [4:0] mask;
    um = (j <= 3'd4) ? (5'd1 << j) : 5'd0;
    exp_q.delete();
    if (!(t <= 2'd1 && j > 3'd4)) begin
      if (t == 2'd0) begin
        repeat (d) exp_q.push_back({um, 3'b010});
      end else if (t == 2'd3) begin
        for (int r = 0; r < NP; r++)
          for (int p = 0; p < NJ; p++)
            repeat (TK) exp_q.push_back({5'(5'd1 << p), 3'b010});
      end else begin
        mask = (t == 2'd2) ? 5'h1f : um;
        for (int r = 0; r < NP; r++) begin
          repeat (TK) exp_q.push_back({mask, 3'b110});
          repeat (TK) exp_q.push_back({5'd0, 3'b010});
        end
      end
    end
    exp_q.push_back(8'b0000_0001);
  endtask

  // driver: called between a negedge and the next posedge while idle
  task automatic run_txn(input logic [1:0] t, input logic [2:0] j, input int d,
                         input int ign, output int lat);
    logic [7:0] ev;
    int k;
    build_expected(t, j, d);
    bus.iniciar  = 1'b1;
    bus.tipo     = t;
    bus.jogador  = j;
    bus.confirma = 1'b0;
    lat = -1;
    k = 0;
    while (exp_q.size() > 0) begin
      @(negedge clock);
      k++;
      ev = exp_q.pop_front();
      check8("trace", k, observa(), ev);
      if (bus.pronto && lat < 0) lat = k;
      bus.iniciar  = (k == ign);
      bus.tipo     = 2'($urandom_range(0, 3));
      bus.jogador  = 3'($urandom_range(0, 7));
      bus.confirma = (t == 2'd0 && j <= 3'd4) ? (k == d) : 1'($urandom_range(0, 1));
    end
    @(negedge clock);
    check8("idle_after", k + 1, observa(), 8'h00);
    bus.iniciar  = 1'b0;
    bus.confirma = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [7:0] ev;
    logic [1:0] rt;
    logic [2:0] rj;

    tabela[0] = '{2'd0, 3'd2, 20, 0,  21};
    tabela[1] = '{2'd1, 3'd4, 0,  6,  25};
    tabela[2] = '{2'd3, 3'd0, 0,  13, 61};
    tabela[3] = '{2'd1, 3'd5, 0,  0,  1};
    tabela[4] = '{2'd0, 3'd7, 0,  1,  1};
    tabela[5] = '{2'd2, 3'd7, 0,  25, 25};
    tabela[6] = '{2'd0, 3'd0, 1,  2,  2};
    tabela[7] = '{2'd1, 3'd6, 0,  0,  1};
    tabela[8] = '{2'd3, 3'd5, 0,  60, 61};
    tabela[9] = '{2'd1, 3'd0, 0,  9,  25};

    bus.iniciar  = 1'b0;
    bus.tipo     = 2'd0;
    bus.jogador  = 3'd0;
    bus.confirma = 1'b0;
    repeat (3) @(negedge clock);
    check8("reset_state", 0, observa(), 8'h00);
    reset = 1'b0;

    // idle: stray confirma must not wake the block
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      check8("idle", i, observa(), 8'h00);
      bus.confirma = 1'($urandom_range(0, 1));
    end
    bus.confirma = 1'b0;

    // table-driven transactions
    for (int v = 0; v < 10; v++) begin
      run_txn(tabela[v].tipo, tabela[v].jogador, tabela[v].conf, tabela[v].ign, lat);
      check_int($sformatf("latency_vec%0d", v), lat, tabela[v].lat);
    end

    // randomized transactions against the model
    for (int n = 0; n < 14; n++) begin
      rt = 2'($urandom_range(0, 3));
      rj = 3'($urandom_range(0, 7));
      run_txn(rt, rj, int'($urandom_range(1, 9)), int'($urandom_range(0, 30)), lat);
    end

    // wolf victory interrupted by an asynchronous reset in cycle 10
    build_expected(2'd2, 3'd0, 0);
    bus.iniciar = 1'b1;
    bus.tipo    = 2'd2;
    bus.jogador = 3'd0;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clock);
      ev = exp_q.pop_front();
      check8("pre_reset", k, observa(), ev);
      bus.iniciar = 1'b0;
    end
    @(posedge clock);
    #1;
    ev = exp_q.pop_front();
    check8("cycle10_before_reset", 10, observa(), ev);
    #1 reset = 1'b1;
    #1;
    check8("async_reset", 10, observa(), 8'h00);
    @(negedge clock);
    check8("in_reset", 11, observa(), 8'h00);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check8("after_release", 0, observa(), 8'h00);
    run_txn(2'd2, 3'd1, 0, 0, lat);
    check_int("latency_after_reset", lat, 25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
